// File: rtl/quiz_pkg.sv
// Shared types and constants for the quiz-round controller.
package quiz_pkg;

    // Round states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        LOCKED  = 2'd2,
        TIMEOUT = 2'd3
    } state_e;

    // Cycles at the start of ARMED during which beep_in is ignored, so a
    // zero left over from the previous round cannot end the new one.
    localparam int BEEP_GUARD_CYCLES = 2;

    // Width of player indices and the widest supported player vector.
    localparam int ID_W        = 3;
    localparam int MAX_PLAYERS = 8;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [ID_W-1:0] prio_enc(input logic [MAX_PLAYERS-1:0] req);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = MAX_PLAYERS - 1; i >= 0; i--) begin
            if (req[i]) idx = ID_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and a one-cycle
// pulse on each rising edge of the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;

    // Count consecutive synchronised samples that disagree with the current
    // level; any agreeing sample restarts the count.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        cnt_d   = '0;
        level_d = level_q;
        pulse_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                level_d = sync2_q;
                pulse_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser, debounce and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: async active-low reset; all state must be listed here, none left to power-up.
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/quiz_arbiter.sv
// Quiz-round controller: conditions the buttons, arms the countdown counter,
// locks in the first buzz, flags timeouts and fouls.
module quiz_arbiter
    import quiz_pkg::*;
#(
    parameter int N_PLAYERS       = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 clock_1,
    input  logic                 reset,
    input  logic                 start_btn,
    input  logic [N_PLAYERS-1:0] player_btn,
    input  logic                 beep_in,
    output logic                 cnt_rst_n,
    output logic                 c_en,
    output logic                 winner_valid,
    output logic [ID_W-1:0]      winner_id,
    output logic                 timeout,
    output logic                 foul_valid,
    output logic [ID_W-1:0]      foul_id,
    output logic [N_PLAYERS-1:0] player_led
);

    logic                 start_pulse;
    logic [N_PLAYERS-1:0] player_pulse;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
        .clk     (clock_1),
        .rst_n   (reset),
        .btn_i   (start_btn),
        .pulse_o (start_pulse)
    );

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_player_db
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_player_db (
            .clk     (clock_1),
            .rst_n   (reset),
            .btn_i   (player_btn[g]),
            .pulse_o (player_pulse[g])
        );
    end

    state_e          state_q,        state_d;
    logic [1:0]      guard_q,        guard_d;
    logic            cnt_rst_n_q,    cnt_rst_n_d;
    logic            c_en_q,         c_en_d;
    logic            winner_valid_q, winner_valid_d;
    logic [ID_W-1:0] winner_id_q,    winner_id_d;
    logic            timeout_q,      timeout_d;
    logic            foul_valid_q,   foul_valid_d;
    logic [ID_W-1:0] foul_id_q,      foul_id_d;

    logic [MAX_PLAYERS-1:0] pulse_wide;
    logic [ID_W-1:0]        pulse_idx;
    logic                   any_pulse;

    // Next state and next values of all registered outputs.
    always_comb begin
        state_d        = state_q;
        guard_d        = guard_q;
        cnt_rst_n_d    = 1'b1;
        c_en_d         = 1'b0;
        winner_valid_d = winner_valid_q;
        winner_id_d    = winner_id_q;
        timeout_d      = timeout_q;
        foul_valid_d   = foul_valid_q;
        foul_id_d      = foul_id_q;

        pulse_wide                 = '0;
        pulse_wide[N_PLAYERS-1:0]  = player_pulse;
        pulse_idx                  = prio_enc(pulse_wide);
        any_pulse                  = |player_pulse;

        // Presses outside ARMED are fouls; only the first is kept.
        if (state_q != ARMED && any_pulse && !foul_valid_q) begin
            foul_valid_d = 1'b1;
            foul_id_d    = pulse_idx;
        end

        case (state_q)
            IDLE: begin
                if (start_pulse) begin
                    state_d        = ARMED;
                    guard_d        = '0;
                    cnt_rst_n_d    = 1'b0;
                    c_en_d         = 1'b1;
                    winner_valid_d = 1'b0;
                    winner_id_d    = '0;
                    timeout_d      = 1'b0;
                    foul_valid_d   = 1'b0;
                    foul_id_d      = '0;
                end
            end
            ARMED: begin
                c_en_d = 1'b1;
                if (guard_q != 2'(BEEP_GUARD_CYCLES)) guard_d = guard_q + 1'b1;
                if (any_pulse) begin
                    state_d        = LOCKED;
                    c_en_d         = 1'b0;
                    winner_valid_d = 1'b1;
                    winner_id_d    = pulse_idx;
                end else if (beep_in && guard_q == 2'(BEEP_GUARD_CYCLES)) begin
                    state_d   = TIMEOUT;
                    c_en_d    = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            LOCKED, TIMEOUT: begin
                if (start_pulse) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock_1 or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            guard_q        <= '0;
            cnt_rst_n_q    <= 1'b1;
            c_en_q         <= 1'b0;
            winner_valid_q <= 1'b0;
            winner_id_q    <= '0;
            timeout_q      <= 1'b0;
            foul_valid_q   <= 1'b0;
            foul_id_q      <= '0;
        end else begin
            state_q        <= state_d;
            guard_q        <= guard_d;
            cnt_rst_n_q    <= cnt_rst_n_d;
            c_en_q         <= c_en_d;
            winner_valid_q <= winner_valid_d;
            winner_id_q    <= winner_id_d;
            timeout_q      <= timeout_d;
            foul_valid_q   <= foul_valid_d;
            foul_id_q      <= foul_id_d;
        end
    end

    // One-hot LED of the registered winner.
    always_comb begin
        player_led = '0;
        if (winner_valid_q) player_led = N_PLAYERS'(1) << winner_id_q;
    end

    assign cnt_rst_n    = cnt_rst_n_q;
    assign c_en         = c_en_q;
    assign winner_valid = winner_valid_q;
    assign winner_id    = winner_id_q;
    assign timeout      = timeout_q;
    assign foul_valid   = foul_valid_q;
    assign foul_id      = foul_id_q;

endmodule
